uart_rx_fifo: RTL and testbench

Standalone UART receiver with mid-bit sampling, optional even parity, framing/break detection and an 8-entry first-word-fall-through receive FIFO. It is the receive-side companion to the team's UART transmit path. It converts the asynchronous RX line into a stream of bytes with per-byte error flags, delivered over a valid/ready handshake to the host logic.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronised RX, mid-bit sampling, optional even parity,
// framing/break detection, feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RX,
    input  logic                     parity_en,
    output logic [7:0]               rx_data,
    output logic                     rx_perr,
    output logic                     rx_ferr,
    output logic                     rx_break,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     rx_busy,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge on rxs
    // S_START  | half a bit in, confirming the start bit
    // S_DATA   | sampling the 8 data bits, LSB first
    // S_PARITY | sampling the even-parity bit
    // S_STOP   | sampling STOP_BITS stop bits, push entry after the last
    // S_BRK    | break received, waiting for the line to return high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_t;

    logic [1:0]    sync_q;
    logic          rxs;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic          stop_q;
    logic [7:0]    shift_q;
    logic          par_en_q;
    logic          perr_q;
    logic          ferr_q;
    logic          push_q;
    logic [10:0]   entry_q;
    logic          ferr_now;
    logic          brk_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX};
    end
    assign rxs = sync_q[1];

    assign ferr_now = ferr_q | ~rxs;
    assign brk_now  = (shift_q == 8'h00) && ferr_now && !rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            push_q   <= 1'b0;
            entry_q  <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q <= S_START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (rxs) begin
                        state_q <= S_IDLE;
                    end else begin
                        par_en_q <= parity_en;
                        cnt_q    <= CNT_FULL;
                        bit_q    <= '0;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            stop_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            perr_q  <= 1'b0;
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        perr_q  <= rxs ^ (^shift_q);
                        cnt_q   <= CNT_FULL;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        cnt_q <= CNT_FULL;
                        if (stop_q == STOP_LAST) begin
                            push_q  <= 1'b1;
                            entry_q <= {brk_now, ferr_now, perr_q, shift_q};
                            state_q <= brk_now ? S_BRK : S_IDLE;
                        end else begin
                            ferr_q <= ferr_now;
                            stop_q <= 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_busy = (state_q != S_IDLE);

    logic [10:0] mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && rx_ready;
    // A pop in the same cycle frees the slot the incoming entry will occupy.
    assign wr_en = push_q && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= entry_q;
                wr_q                <= wr_q + PTR_ONE;
            end
            if (pop) rd_q <= rd_q + PTR_ONE;
            if (push_q && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)           overflow <= 1'b0;
        end
    end

    assign {rx_break, rx_ferr, rx_perr, rx_data} = mem_q[rd_q[AW-1:0]];
    assign rx_valid = !empty;
    assign rx_count = wr_q - rd_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: frames are built bit by bit on RX and a
// queue model predicts every FIFO output cycle by cycle.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int STOPB = 1;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       parity_en;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_break, rx_valid;
    logic       rx_ready;
    logic [3:0] rx_count;
    logic       rx_busy, overflow, ovf_clr;

    logic man_rdy = 1'b0;
    logic rnd_rdy = 1'b0;
    logic rand_mode = 1'b0;
    assign rx_ready = rand_mode ? rnd_rdy : man_rdy;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .RX(RX), .parity_en(parity_en),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_break(rx_break), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_busy(rx_busy), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: entries in flight with the cycle they become visible, plus the FIFO.
    typedef struct {
        int          vis;
        logic [10:0] e;
    } pend_t;
    pend_t       pend_q[$];
    logic [10:0] fifo_q[$];
    bit          ovf_m = 1'b0;
    bit          pop_m, push_m, set_m;

    // Start bit driven in cycle c -> rxs low at c+2 -> last sample after n more bits,
    // push register one cycle later, visible the cycle after that.
    task automatic add_pending(input int c, input int nbits, input logic [10:0] e);
        pend_t p;
        p.vis = c + 2 + CPB / 2 + nbits * CPB + 2;
        p.e   = e;
        pend_q.push_back(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit par_ok, input bit stop_ok);
        int   n;
        logic pbit;
        n = 8 + (par ? 1 : 0) + STOPB;
        pbit = par_ok ? ^d : ~(^d);
        add_pending(cyc, n, {(d == 8'h00) && !stop_ok, !stop_ok, par && !par_ok, d});
        parity_en = par;
        RX = 1'b0;
        wait_cyc(CPB);
        for (int k = 0; k < 8; k++) begin
            RX = d[k];
            wait_cyc(CPB);
        end
        if (par) begin
            RX = pbit;
            wait_cyc(CPB);
        end
        for (int s = 0; s < STOPB; s++) begin
            RX = stop_ok;
            wait_cyc(CPB);
        end
        RX = 1'b1;
    endtask

    task automatic pop1();
        man_rdy = 1'b1;
        wait_cyc(1);
        man_rdy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fifo_q.delete();
            pend_q.delete();
            ovf_m = 1'b0;
        end else begin
            chk("valid", rx_valid, fifo_q.size() != 0);
            chk("count", rx_count, fifo_q.size());
            chk("overflow", overflow, ovf_m);
            if (fifo_q.size() != 0) begin
                chk("head_data", rx_data, fifo_q[0][7:0]);
                chk("head_perr", rx_perr, fifo_q[0][8]);
                chk("head_ferr", rx_ferr, fifo_q[0][9]);
                chk("head_break", rx_break, fifo_q[0][10]);
            end
            pop_m  = (fifo_q.size() != 0) && rx_ready;
            push_m = (pend_q.size() != 0) && (pend_q[0].vis == cyc + 1);
            set_m  = 1'b0;
            if (pop_m) void'(fifo_q.pop_front());
            if (push_m) begin
                if (fifo_q.size() >= DEPTH) set_m = 1'b1;
                else fifo_q.push_back(pend_q[0].e);
                void'(pend_q.pop_front());
            end
            if (set_m)        ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [7:0]  d;
        bit          par, pok, sok;
        rst = 1'b1; RX = 1'b1; parity_en = 1'b0; ovf_clr = 1'b0;
        wait_cyc(5);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_head", {rx_break, rx_ferr, rx_perr, rx_data}, 0);
        rst = 1'b0;
        wait_cyc(3);

        send_frame(8'hA5, 0, 1, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_flags", {rx_break, rx_ferr, rx_perr}, 0);
        chk("a5_count", rx_count, 1);
        pop1();
        chk("a5_popped", rx_valid, 0);

        send_frame(8'h07, 1, 1, 1);
        chk("par_ok", rx_perr, 0);
        pop1();
        send_frame(8'h07, 1, 0, 1);
        chk("par_bad", rx_perr, 1);
        chk("par_bad_data", rx_data, 8'h07);
        pop1();

        RX = 1'b0;
        wait_cyc(4);
        RX = 1'b1;
        chk("glitch_busy", rx_busy, 1);
        wait_cyc(8);
        chk("glitch_idle", rx_busy, 0);
        chk("glitch_count", rx_count, 0);

        send_frame(8'h3C, 0, 1, 0);
        chk("ferr_flag", rx_ferr, 1);
        chk("ferr_nobrk", rx_break, 0);
        chk("ferr_data", rx_data, 8'h3C);
        pop1();
        wait_cyc(20);

        c = cyc;
        add_pending(c, 8 + STOPB, 11'h600);
        RX = 1'b0;
        wait_cyc(400);
        chk("brk_busy", rx_busy, 1);
        chk("brk_one", rx_count, 1);
        chk("brk_head", {rx_break, rx_ferr, rx_perr, rx_data}, 11'h600);
        wait_cyc(240);
        RX = 1'b1;
        wait_cyc(1);
        chk("brk_busy_hold", rx_busy, 1);
        wait_cyc(9);
        chk("brk_released", rx_busy, 0);
        chk("brk_still_one", rx_count, 1);
        pop1();

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 1);
        chk("ovf_count", rx_count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", rx_data, 8'h01);
        man_rdy = 1'b1;
        wait_cyc(8);
        man_rdy = 1'b0;
        chk("ovf_drained", rx_count, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 0, 1, 1);
        fork
            send_frame(8'h09, 0, 1, 1);
            begin
                wait_cyc(2 + CPB / 2 + 9 * CPB + 1);
                man_rdy = 1'b1;
                wait_cyc(1);
                man_rdy = 1'b0;
            end
        join
        chk("fullpop_count", rx_count, 8);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_head", rx_data, 8'h12);
        man_rdy = 1'b1;
        wait_cyc(8);
        man_rdy = 1'b0;
        chk("fullpop_drained", rx_count, 0);

        rand_mode = 1'b1;
        repeat (25) begin
            d   = 8'($urandom);
            par = ($urandom_range(0, 1) == 1);
            pok = ($urandom_range(0, 3) != 0);
            sok = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            send_frame(d, par, pok, sok);
            wait_cyc(sok ? $urandom_range(0, 20) : $urandom_range(20, 40));
        end
        rand_mode = 1'b0;
        man_rdy = 1'b1;
        wait_cyc(20);
        man_rdy = 1'b0;
        chk("rand_drained", rx_count, 0);

        send_frame(8'h5A, 0, 1, 1);
        chk("mid_pre_count", rx_count, 1);
        RX = 1'b0;
        wait_cyc(60);
        chk("mid_busy", rx_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_count", rx_count, 0);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_head", {rx_break, rx_ferr, rx_perr, rx_data}, 0);
        RX = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        chk("post_rst_busy", rx_busy, 0);
        chk("post_rst_valid", rx_valid, 0);

        wait_cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
